// File: rtl/cdc_tx_pkg.sv
// Shared types and defaults for the strobe-qualified CDC transmitter.
package cdc_tx_pkg;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_HOLD_CYCLES    = 2;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE
    } cdc_tx_state_e;

    // One counter serves both the settle hold and the handshake timeout.
    function automatic int cnt_width(input int hold, input int timeout);
        int max_val;
        max_val = (hold > timeout) ? hold : timeout;
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cdc_strobe_tx_bit_sync.sv
// bit_sync: SYNC_STAGES-deep flop chain bringing a single asynchronous bit into clk.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_strobe_tx.sv
// Source half of a four-phase strobe/ack crossing: hold data, raise strobe, wait for ack.
// Optional handshake abort/sticky err is built when CDC_TX_TIMEOUT_EN is defined.
module cdc_strobe_tx
    import cdc_tx_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              stb_out,
    input  logic              ack_async,
    output logic              done,
    output logic              err
);

    // state   | meaning
    // IDLE    | ready for a word; data_out holds the previous word
    // SETUP   | new word on the bus, counting settle cycles, waiting out any stale ack
    // REQ     | stb_out high, waiting for ack
    // RELEASE | stb_out low, waiting for ack to drop

    localparam int CNT_W = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef CDC_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    cdc_tx_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic             ack_sync;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ack_async),
        .dout (ack_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= '0;
            stb_out  <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b1;
`ifdef CDC_TX_TIMEOUT_EN
            err      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data_out <= tx_data;
                        cnt      <= '0;
                        tx_ready <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    // Counter parks at the last value while a stale ack is still visible.
                    if (cnt != HOLD_LAST) begin
                        cnt <= cnt + CNT_ONE;
                    end else if (!ack_sync) begin
                        stb_out <= 1'b1;
                        cnt     <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack_sync) begin
                        stb_out <= 1'b0;
                        cnt     <= '0;
                        state   <= RELEASE;
                    end
`ifdef CDC_TX_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        stb_out  <= 1'b0;
                        err      <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
`endif
                end
                RELEASE: begin
                    if (!ack_sync) begin
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
`ifdef CDC_TX_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        err      <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef CDC_TX_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_strobe_tx.sv
// Scoreboard bench for cdc_strobe_tx: words pushed on accept, popped and checked on done.
module tb_cdc_strobe_tx;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] data_out;
    logic       stb_out;
    logic       ack_async;
    logic       done;
    logic       err;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    logic [7:0] exp_q[$];

    cdc_strobe_tx #(
        .DATA_W         (8),
        .HOLD_CYCLES    (2),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .data_out  (data_out),
        .stb_out   (stb_out),
        .ack_async (ack_async),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input logic v, input int max_cyc, output int cyc);
        cyc = 0;
        while (stb_out !== v && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    // Scoreboard monitor: every done pulse retires the oldest accepted word.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 32'(data_out), 32'hDEAD);
            end else begin
                chk("sb_data_at_done", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int c;
        int acc_cnt;
        int d_cnt;
        int first_done_cyc;
        int second_acc_cyc;
        int done_before;
        logic ready_before;

        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        ack_async = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_stb", 32'(stb_out), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);

        // Basic transfer plus bus stability while in REQ
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tick();
        exp_q.push_back(8'h55);
        tx_valid = 1'b0;
        chk("acc_tx_ready_low", 32'(tx_ready), 0);
        wait_stb(1'b1, 20, c);
        chk("basic_stb_rise_lat", 32'(c), 2);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        chk("stab_data_hold", 32'(data_out), 32'h55);
        chk("stab_tx_ready", 32'(tx_ready), 0);
        tick();
        tx_valid = 1'b0;
        tick();
        chk("req_stb_held", 32'(stb_out), 1);
        ack_async = 1'b1;
        wait_stb(1'b0, 20, c);
        chk("basic_stb_fall_lat", 32'(c), 3);
        chk("basic_data_release", 32'(data_out), 32'h55);
        ack_async = 1'b0;
        wait_done(20, c);
        chk("basic_done_lat", 32'(c), 3);
        chk("done_tx_ready", 32'(tx_ready), 1);
        tick();
        chk("done_one_cycle", 32'(done), 0);

        // Back-to-back with an ack that follows stb_out
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        acc_cnt = 0;
        d_cnt = 0;
        first_done_cyc = -1;
        second_acc_cyc = -1;
        for (int i = 0; i < 200 && d_cnt < 2; i++) begin
            ready_before = tx_ready;
            tick();
            if (ready_before && tx_valid) begin
                acc_cnt++;
                exp_q.push_back(tx_data);
                if (acc_cnt == 1) begin
                    tx_data = 8'h3C;
                end else begin
                    second_acc_cyc = i;
                    tx_valid = 1'b0;
                end
            end
            if (done === 1'b1) begin
                d_cnt++;
                if (d_cnt == 1) first_done_cyc = i;
            end
            ack_async = stb_out;
        end
        tx_valid  = 1'b0;
        ack_async = 1'b0;
        chk("b2b_done_count", 32'(d_cnt), 2);
        chk("b2b_accept_count", 32'(acc_cnt), 2);
        chk("b2b_second_accept_cyc", 32'(second_acc_cyc), 32'(first_done_cyc + 1));
        tick();
        tick();

        // Stale ack held across accept
        ack_async = 1'b1;
        tick();
        tick();
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'h96;
        tick();
        exp_q.push_back(8'h96);
        tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("stale_stb_low", 32'(stb_out), 0);
        ack_async = 1'b0;
        wait_stb(1'b1, 20, c);
        chk("stale_stb_rise_lat", 32'(c), 3);
        ack_async = 1'b1;
        wait_stb(1'b0, 20, c);
        chk("stale_stb_fall_lat", 32'(c), 3);
        ack_async = 1'b0;
        wait_done(20, c);
        chk("stale_done_lat", 32'(c), 3);
        tick();

        // Reset while stb_out is high
        done_before = n_done;
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        wait_stb(1'b1, 20, c);
        chk("mid_stb_rise_lat", 32'(c), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_stb", 32'(stb_out), 0);
        chk("mid_rst_data", 32'(data_out), 0);
        chk("mid_rst_tx_ready", 32'(tx_ready), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_rst_no_done", 32'(n_done), 32'(done_before));

`ifdef CDC_TX_TIMEOUT_EN
        // Never acknowledge: abort after TIMEOUT_CYCLES in REQ
        done_before = n_done;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        tick();
        tx_valid = 1'b0;
        wait_stb(1'b1, 20, c);
        chk("to_stb_rise_lat", 32'(c), 2);
        chk("to_err_before", 32'(err), 0);
        wait_stb(1'b0, 60, c);
        chk("to_stb_fall_lat", 32'(c), 16);
        chk("to_err_set", 32'(err), 1);
        chk("to_tx_ready", 32'(tx_ready), 1);
        for (int i = 0; i < 10; i++) tick();
        chk("to_err_sticky", 32'(err), 1);
        chk("to_no_done", 32'(n_done), 32'(done_before));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_err_cleared", 32'(err), 0);
`else
        chk("err_tied_low", 32'(err), 0);
`endif

        chk("sb_queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
